// File: rtl/pattern_loader.sv
// pattern_loader: serial host that shifts buffered bytes out on sclk/ssel/saddr/sin and captures sout.
// Build option PATLOAD_PARITY_EN: appends an odd-parity bit to every byte and reports rd_perr.
module pattern_loader #(
   parameter int CLKDIV   = 2,
   parameter int BUFBYTES = 27,
   parameter int CNTW     = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_buf,
   input  logic [7:0] in_data,
   input  logic       in_last,
   output logic       sclk,
   output logic       ssel,
   output logic [2:0] saddr,
   output logic       sin,
   input  logic       sout,
   output logic       rd_valid,
   output logic [7:0] rd_data,
`ifdef PATLOAD_PARITY_EN
   output logic       rd_perr,
`endif
   output logic       busy,
   output logic       ovf
);
`ifdef PATLOAD_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif
   localparam int TW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [TW-1:0]   TLAST = TW'(CLKDIV - 1);
   localparam logic [3:0]      BLAST = 4'(NB - 1);
   localparam logic [CNTW-1:0] CMAX  = CNTW'(BUFBYTES);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD} state_t;

`ifdef PATLOAD_PARITY_EN
   function automatic logic odd_par(input logic [7:0] d);
      return ~(^d);
   endfunction
`endif

   // Word shifted out per byte: data MSB first, optionally followed by its parity bit.
   function automatic logic [NB-1:0] load_word(input logic [7:0] d);
`ifdef PATLOAD_PARITY_EN
      return {d, odd_par(d)};
`else
      return d;
`endif
   endfunction

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [3:0]      bit_q, bit_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            last_q, last_d;
   logic [NB-2:0]   tx_q, tx_d;
   logic [NB-1:0]   rx_q, rx_d;
   logic            sclk_q, sclk_d, ssel_q, ssel_d, sin_q, sin_d;
   logic [2:0]      saddr_q, saddr_d;
   logic            rd_valid_q, rd_valid_d;
   logic [7:0]      rd_data_q, rd_data_d;
   logic            rd_perr_q, rd_perr_d;
   logic            busy_q, busy_d, in_ready_q, in_ready_d, ovf_q, ovf_d;
   logic            accept;
   logic [NB-1:0]   word;

   // Next-state and next-output computation for the whole frame sequencer.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      bit_d      = bit_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      sclk_d     = sclk_q;
      ssel_d     = ssel_q;
      sin_d      = sin_q;
      saddr_d    = saddr_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      rd_perr_d  = rd_perr_q;
      ovf_d      = ovf_q;
      accept     = in_valid && in_ready_q;
      word       = load_word(in_data);
      case (state_q)
         IDLE: begin
            if (accept) begin
               saddr_d = in_buf;
               cnt_d   = CNTW'(1);
               ovf_d   = 1'b0;
               ssel_d  = 1'b1;
               sin_d   = word[NB-1];
               tx_d    = word[NB-2:0];
               last_d  = in_last;
               timer_d = '0;
               bit_d   = 4'd0;
               state_d = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            if (timer_q == TLAST) begin
               timer_d = '0;
               state_d = SHIFT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         SHIFT: begin
            if (timer_q != TLAST) begin
               timer_d = timer_q + 1'b1;
            end else begin
               timer_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[NB-2:0], sout};
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == BLAST) begin
                     // Final falling edge closes the byte and hands back the captured word.
                     sin_d      = 1'b0;
                     bit_d      = 4'd0;
                     rd_valid_d = 1'b1;
                     rd_data_d  = rx_q[NB-1 -: 8];
                     rd_perr_d  = ~(^rx_q);
                     state_d    = last_q ? HOLD : GAP;
                  end else begin
                     bit_d = bit_q + 4'd1;
                     sin_d = tx_q[NB-2];
                     tx_d  = {tx_q[NB-3:0], 1'b0};
                  end
               end
            end
         end
         GAP: begin
            if (accept) begin
               if (cnt_q < CMAX) begin
                  cnt_d   = cnt_q + CNTW'(1);
                  sin_d   = word[NB-1];
                  tx_d    = word[NB-2:0];
                  last_d  = in_last;
                  timer_d = '0;
                  bit_d   = 4'd0;
                  state_d = SHIFT;
               end else begin
                  // Buffer already full: drop the byte but still honour its frame end.
                  ovf_d   = 1'b1;
                  timer_d = '0;
                  state_d = in_last ? HOLD : GAP;
               end
            end else begin
               state_d = GAP;
            end
         end
         HOLD: begin
            if (timer_q == TLAST) begin
               timer_d = '0;
               ssel_d  = 1'b0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d = (state_d == IDLE) || (state_d == GAP);
      busy_d     = (state_d != IDLE);
   end

   // State and registered outputs; reset drops the frame immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         bit_q      <= 4'd0;
         cnt_q      <= '0;
         last_q     <= 1'b0;
         tx_q       <= '0;
         rx_q       <= '0;
         sclk_q     <= 1'b0;
         ssel_q     <= 1'b0;
         sin_q      <= 1'b0;
         saddr_q    <= 3'd0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 8'd0;
         rd_perr_q  <= 1'b0;
         busy_q     <= 1'b0;
         in_ready_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         bit_q      <= bit_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         sclk_q     <= sclk_d;
         ssel_q     <= ssel_d;
         sin_q      <= sin_d;
         saddr_q    <= saddr_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_perr_q  <= rd_perr_d;
         busy_q     <= busy_d;
         in_ready_q <= in_ready_d;
         ovf_q      <= ovf_d;
      end
   end

   assign sclk     = sclk_q;
   assign ssel     = ssel_q;
   assign sin      = sin_q;
   assign saddr    = saddr_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign busy     = busy_q;
   assign in_ready = in_ready_q;
   assign ovf      = ovf_q;
`ifdef PATLOAD_PARITY_EN
   assign rd_perr  = rd_perr_q;
`else
   logic unused_perr;
   assign unused_perr = rd_perr_q;
`endif

endmodule

// File: doc/pattern_loader.md
Name: pattern_loader

Overview:
- Serial host (master) for the pattern-buffer configuration port.
- Accepts parallel byte writes (buffer index + data + last flag) over a valid/ready handshake.
- Drives sclk/ssel/saddr/sin to the buffers block and captures sout full-duplex as readback bytes.
- Sits between the control/CPU side and the 8-buffer x 27-byte pattern store.

Parameters:
- CLKDIV, 2, sclk half-period in clk cycles (>=1).
- BUFBYTES, 27, bytes per pattern buffer; frame byte limit.
- CNTW, 5, width of the frame byte counter (must hold BUFBYTES).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  byte write request.
- in_ready  output  1  loader can accept a byte.
- in_buf  input  3  target buffer index; sampled on the first byte of a frame only.
- in_data  input  8  byte to shift out, MSB first.
- in_last  input  1  byte closes the frame; ssel drops after it.
- sclk  output  1  serial clock to buffers, idle low.
- ssel  output  1  frame select, active high.
- saddr  output  3  buffer index, constant for the whole frame.
- sin  output  1  serial data to buffers.
- sout  input  1  serial data from buffers.
- rd_valid  output  1  one-cycle pulse: readback byte complete.
- rd_data  output  8  sout bits captured during the last byte, MSB first.
- busy  output  1  high whenever FSM is not IDLE.
- ovf  output  1  sticky: frame exceeded BUFBYTES; cleared at next frame start.

Behaviour:
- Reset: all outputs low (sclk=0, ssel=0, saddr=0, sin=0, rd_data=0, rd_valid=0, ovf=0, busy=0, in_ready=0 during reset). FSM=IDLE, counters=0.
- Handshake: transfer occurs on the clk edge where in_valid && in_ready. in_ready=1 only in IDLE and GAP. Data is latched into the shift register on acceptance.
- States:
  - IDLE
    - Accept: latch saddr=in_buf, byte count=1, clear ovf, ssel=1, go SETUP.
  - SETUP
    - sin = data MSB; wait CLKDIV cycles (address/select setup), go SHIFT.
  - SHIFT
    - Per bit: sclk low for CLKDIV cycles with sin stable, then sclk high for CLKDIV cycles.
    - Capture sout into the rd shift register on the clk cycle sclk rises.
    - sin advances to the next bit on the cycle sclk falls.
    - 8 bits = 16*CLKDIV cycles.
    - After bit 0 falls: rd_valid pulses 1 cycle with rd_data; go GAP if the byte was not last, else HOLD.
  - GAP
    - ssel held, sclk low, in_ready=1.
    - Accept with count<BUFBYTES: count++, go SHIFT; sin = MSB on the accept cycle+1.
    - Accept with count==BUFBYTES: byte discarded, ovf=1. If in_last, go HOLD; else stay GAP.
  - HOLD
    - ssel stays 1 for CLKDIV cycles, then ssel=0, go IDLE.
- Whenever an accepted byte has in_last=1, the frame ends after that byte (or immediately for a discarded overflow byte).
- in_buf is ignored on non-first bytes.
- Single-byte frame (in_last on the first byte) is legal: IDLE->SETUP->SHIFT->HOLD->IDLE.
- rst_n asserted mid-frame: immediate return to reset values; ssel drops asynchronously. No partial rd_valid.
- sclk never glitches: it only toggles in SHIFT at half-period boundaries.

Optional Feature:
- Macro: PATLOAD_PARITY_EN.
- Defined:
  - A 9th bit (odd parity of the data byte) is shifted after bit 0 of each byte, extending SHIFT to 18*CLKDIV cycles.
  - The 9th sout bit is checked as odd parity of the captured byte.
  - Adds output rd_perr (1 bit, reset 0), valid with rd_valid; high on mismatch.
- Undefined: 8-bit frames only; rd_perr port absent.

Test Plan:
- Reset mid-SHIFT with CLKDIV=2 -> ssel/sclk/sin=0 within the reset assertion; busy=0; after release, in_ready=1 in IDLE.
- Single byte, in_buf=5, in_data=0xA5, in_last=1, CLKDIV=2 -> saddr=5, ssel high.
  - sin sequence 1,0,1,0,0,1,0,1 at 8 sclk rises.
  - Byte occupies 32 cycles of SHIFT.
  - ssel low 2 cycles after the last fall.
- sout driven 0x3C, MSB first, on rising edges -> rd_valid one pulse, rd_data=0x3C.
- 27-byte frame to buffer 7 (data 0..26), last on byte 27 -> ssel continuous across all bytes; 27 rd_valid pulses; ovf=0.
- 28-byte frame -> 28th byte accepted but not shifted (no sclk edges); ovf=1; ssel drops. Next frame start clears ovf.
- PATLOAD_PARITY_EN, data 0x01 -> 9th sin bit=0. sout returns 0x01 with 9th bit 1 -> rd_perr=1; with 9th bit 0 -> rd_perr=0.
